// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - byte-serial RAM/IO controller for fetch and load-store clients
// LSB requests take priority over fetch; little-endian word assembly.
`ifndef OP_TYPE
`define OP_TYPE 0:0
`endif
`ifndef OPTYPE_LD
`define OPTYPE_LD 1'b0
`endif
`ifndef OPTYPE_ST
`define OPTYPE_ST 1'b1
`endif

module memory_controller #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clr_in,
    input  logic              lsb_to_mc_ready,
    input  logic [1:0]        lsb_to_mc_len,
    input  logic [`OP_TYPE]   lsb_to_mc_opType,
    input  logic [31:0]       lsb_to_mc_addr,
    input  logic [31:0]       lsb_to_mc_data,
    output logic              mc_valid,
    output logic              mc_to_lsb_ld_done,
    output logic              mc_to_lsb_st_done,
    output logic [31:0]       mc_to_lsb_result,
    input  logic              if_to_mc_ready,
    input  logic [31:0]       if_to_mc_addr,
    output logic              mc_to_if_done,
    output logic [31:0]       mc_to_if_inst,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [31:0]       mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_FETCH} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  r_len_n;
    logic [31:0] r_base;
    logic [31:0] r_st_data;
    logic [31:0] r_asm;
    logic [31:0] r_ld_res;
    logic [31:0] r_inst;
    logic        r_valid;
    logic        r_rdy_q;

    logic        w_rd_state;
    logic        w_last;
    logic        w_replay;
    logic        w_capture;
    logic        w_ld_fin;
    logic        w_if_fin;
    logic        w_st_fin;
    logic        w_arb;
    logic        w_take_lsb;
    logic        w_take_if;
    logic        w_io_stall;
    logic [31:0] w_cur_addr;
    logic [1:0]  w_byte_idx;
    logic [31:0] w_asm;
    logic [2:0]  w_len_dec;

    assign w_rd_state = (r_state == S_LOAD) || (r_state == S_FETCH);
    assign w_last     = (r_cnt == r_len_n);
    assign w_cur_addr = r_base + {29'b0, r_cnt};
    assign w_byte_idx = r_cnt[1:0] - 2'd1;

    // After a freeze the byte on mem_din is stale, so the previous address is shown once more.
    assign w_replay   = w_rd_state && rdy_in && !r_rdy_q && (r_cnt != 3'd0);
    assign w_capture  = w_rd_state && (r_cnt != 3'd0) && !w_replay;

    assign w_ld_fin   = (r_state == S_LOAD)  && w_last && !w_replay;
    assign w_if_fin   = (r_state == S_FETCH) && w_last && !w_replay && !clr_in;
    assign w_st_fin   = (r_state == S_STORE) && w_last;
    assign w_io_stall = (r_state == S_STORE) && !w_last
                        && (w_cur_addr[17:16] == IO_ADDR_HI) && io_buffer_full;

    // The held fetch request is still visible during its own done cycle, so it is not re-taken there.
    assign w_arb      = (r_state == S_IDLE) || w_ld_fin || w_if_fin || w_st_fin;
    assign w_take_lsb = w_arb && lsb_to_mc_ready;
    assign w_take_if  = w_arb && !lsb_to_mc_ready && if_to_mc_ready && !clr_in && !w_if_fin;

    always_comb begin
        w_asm = r_asm;
        if (w_capture) begin
            w_asm[{w_byte_idx, 3'b000} +: 8] = mem_din;
        end
    end

    always_comb begin
        case (lsb_to_mc_len)
            2'b10:   w_len_dec = 3'd2;
            2'b11:   w_len_dec = 3'd4;
            default: w_len_dec = 3'd1;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_LOAD:  if (w_ld_fin) w_state_nxt = S_IDLE;
            S_STORE: if (w_st_fin) w_state_nxt = S_IDLE;
            S_FETCH: if (clr_in || w_if_fin) w_state_nxt = S_IDLE;
        endcase
        if (w_take_lsb) begin
            w_state_nxt = (lsb_to_mc_opType == `OPTYPE_ST) ? S_STORE : S_LOAD;
        end else if (w_take_if) begin
            w_state_nxt = S_FETCH;
        end
    end

    always_comb begin
        mem_a             = 32'd0;
        mem_dout          = 8'd0;
        mem_wr            = 1'b0;
        case (r_state)
            S_LOAD, S_FETCH: begin
                if (w_replay) begin
                    mem_a = w_cur_addr - 32'd1;
                end else if (!w_last) begin
                    mem_a = w_cur_addr;
                end
            end
            S_STORE: begin
                if (!w_last) begin
                    mem_a    = w_cur_addr;
                    mem_dout = r_st_data[{r_cnt[1:0], 3'b000} +: 8];
                    mem_wr   = !w_io_stall;
                end
            end
            default: mem_a = 32'd0;
        endcase
        mc_valid          = r_valid;
        mc_to_lsb_ld_done = w_ld_fin;
        mc_to_lsb_st_done = w_st_fin;
        mc_to_if_done     = w_if_fin;
        mc_to_lsb_result  = w_ld_fin ? w_asm : r_ld_res;
        mc_to_if_inst     = w_if_fin ? w_asm : r_inst;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rdy_q <= 1'b1;
        end else begin
            r_rdy_q <= rdy_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt     <= 3'd0;
            r_len_n   <= 3'd0;
            r_base    <= 32'd0;
            r_st_data <= 32'd0;
            r_asm     <= 32'd0;
            r_ld_res  <= 32'd0;
            r_inst    <= 32'd0;
            r_valid   <= 1'b0;
        end else if (rdy_in) begin
            r_valid <= w_take_lsb;
            if (w_ld_fin) r_ld_res <= w_asm;
            if (w_if_fin) r_inst   <= w_asm;
            if (w_take_lsb) begin
                r_base    <= lsb_to_mc_addr;
                r_st_data <= lsb_to_mc_data;
                r_len_n   <= w_len_dec;
                r_cnt     <= 3'd0;
                r_asm     <= 32'd0;
            end else if (w_take_if) begin
                r_base    <= if_to_mc_addr;
                r_len_n   <= 3'd4;
                r_cnt     <= 3'd0;
                r_asm     <= 32'd0;
            end else if (w_state_nxt == S_IDLE) begin
                r_cnt     <= 3'd0;
            end else begin
                if (w_capture) r_asm <= w_asm;
                if (w_rd_state && !w_last && !w_replay) begin
                    r_cnt <= r_cnt + 3'd1;
                end else if ((r_state == S_STORE) && !w_last && !w_io_stall) begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - directed self-checking bench for memory_controller
`ifndef OP_TYPE
`define OP_TYPE 0:0
`endif
`ifndef OPTYPE_LD
`define OPTYPE_LD 1'b0
`endif
`ifndef OPTYPE_ST
`define OPTYPE_ST 1'b1
`endif

module tb_memory_controller;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             clr_in;
    logic             lsb_to_mc_ready;
    logic [1:0]       lsb_to_mc_len;
    logic [`OP_TYPE]  lsb_to_mc_opType;
    logic [31:0]      lsb_to_mc_addr;
    logic [31:0]      lsb_to_mc_data;
    logic             mc_valid;
    logic             mc_to_lsb_ld_done;
    logic             mc_to_lsb_st_done;
    logic [31:0]      mc_to_lsb_result;
    logic             if_to_mc_ready;
    logic [31:0]      if_to_mc_addr;
    logic             mc_to_if_done;
    logic [31:0]      mc_to_if_inst;
    logic [7:0]       mem_din;
    logic [7:0]       mem_dout;
    logic [31:0]      mem_a;
    logic             mem_wr;
    logic             io_buffer_full;

    always #5 clk_in = ~clk_in;

    memory_controller #(.IO_ADDR_HI(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .lsb_to_mc_ready(lsb_to_mc_ready), .lsb_to_mc_len(lsb_to_mc_len),
        .lsb_to_mc_opType(lsb_to_mc_opType), .lsb_to_mc_addr(lsb_to_mc_addr),
        .lsb_to_mc_data(lsb_to_mc_data), .mc_valid(mc_valid),
        .mc_to_lsb_ld_done(mc_to_lsb_ld_done), .mc_to_lsb_st_done(mc_to_lsb_st_done),
        .mc_to_lsb_result(mc_to_lsb_result), .if_to_mc_ready(if_to_mc_ready),
        .if_to_mc_addr(if_to_mc_addr), .mc_to_if_done(mc_to_if_done),
        .mc_to_if_inst(mc_to_if_inst), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    logic [7:0] ram [0:65535];
    int cyc = 0;

    always @(posedge clk_in) begin
        cyc     <= cyc + 1;
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr === 1'b1) ram[mem_a[15:0]] = mem_dout;
    end

    int n_valid = 0, n_ld = 0, n_st = 0, n_if = 0, n_wr = 0;
    int valid_cyc, ld_cyc, st_cyc, if_cyc;
    logic [31:0] ld_res, if_inst;
    logic [31:0] wr_a [16];
    logic [7:0]  wr_d [16];
    int          wr_c [16];

    always @(negedge clk_in) begin
        if (rdy_in === 1'b1) begin
            if (mc_valid === 1'b1) begin n_valid++; valid_cyc = cyc; end
            if (mc_to_lsb_ld_done === 1'b1) begin n_ld++; ld_cyc = cyc; ld_res = mc_to_lsb_result; end
            if (mc_to_lsb_st_done === 1'b1) begin n_st++; st_cyc = cyc; end
            if (mc_to_if_done === 1'b1) begin n_if++; if_cyc = cyc; if_inst = mc_to_if_inst; end
            if (mem_wr === 1'b1) begin
                if (n_wr < 16) begin wr_a[n_wr] = mem_a; wr_d[n_wr] = mem_dout; wr_c[n_wr] = cyc; end
                n_wr++;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic lsb_issue(input logic st, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
        int n;
        lsb_to_mc_opType = st ? `OPTYPE_ST : `OPTYPE_LD;
        lsb_to_mc_len    = len;
        lsb_to_mc_addr   = a;
        lsb_to_mc_data   = d;
        lsb_to_mc_ready  = 1'b1;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!(mc_valid === 1'b1 && rdy_in === 1'b1) && n < 40);
        check("lsb_accept", {31'b0, mc_valid}, 32'd1);
        step(1);
        lsb_to_mc_ready = 1'b0;
    endtask

    int v0, l0, s0, f0, w0;

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22; ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
        ram[16'h0300] = 8'hA5;
        ram[16'h0400] = 8'h01; ram[16'h0401] = 8'h02; ram[16'h0402] = 8'h03; ram[16'h0403] = 8'h04;

        rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full = 1'b0;
        lsb_to_mc_ready = 1'b0; lsb_to_mc_len = 2'b00; lsb_to_mc_opType = `OPTYPE_LD;
        lsb_to_mc_addr = 32'd0; lsb_to_mc_data = 32'd0;
        if_to_mc_ready = 1'b0; if_to_mc_addr = 32'd0;

        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_mem_wr",   {31'b0, mem_wr}, 32'd0);
        check("rst_mem_a",    mem_a, 32'd0);
        check("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
        check("rst_valid",    {31'b0, mc_valid}, 32'd0);
        check("rst_result",   mc_to_lsb_result, 32'd0);
        check("rst_inst",     mc_to_if_inst, 32'd0);
        check("rst_pulses",   {29'b0, mc_to_lsb_ld_done, mc_to_lsb_st_done, mc_to_if_done}, 32'd0);
        step(1);
        rst_in = 1'b0;
        step(1);

        // LW 0x100
        v0 = n_valid; l0 = n_ld;
        lsb_issue(1'b0, 2'b11, 32'h0000_0100, 32'd0);
        step(8);
        check("lw_valid_once", 32'(n_valid - v0), 32'd1);
        check("lw_done_once",  32'(n_ld - l0), 32'd1);
        check("lw_latency",    32'(ld_cyc - valid_cyc), 32'd4);
        check("lw_result",     ld_res, 32'h4433_2211);

        // SH 0x205
        s0 = n_st; w0 = n_wr;
        lsb_issue(1'b1, 2'b10, 32'h0000_0205, 32'hDEAD_BEEF);
        step(6);
        check("sh_nwrites", 32'(n_wr - w0), 32'd2);
        check("sh_a0", wr_a[w0], 32'h0000_0205);
        check("sh_d0", {24'b0, wr_d[w0]}, 32'h0000_00EF);
        check("sh_a1", wr_a[w0+1], 32'h0000_0206);
        check("sh_d1", {24'b0, wr_d[w0+1]}, 32'h0000_00BE);
        check("sh_first_wr", 32'(wr_c[w0] - valid_cyc), 32'd0);
        check("sh_done_lat", 32'(st_cyc - valid_cyc), 32'd2);
        check("sh_done_once", 32'(n_st - s0), 32'd1);
        check("sh_ram", {16'b0, ram[16'h0206], ram[16'h0205]}, 32'h0000_BEEF);

        // LB and fetch raised together: LSB first, fetch back-to-back
        l0 = n_ld; f0 = n_if;
        if_to_mc_addr  = 32'h0000_0400;
        if_to_mc_ready = 1'b1;
        lsb_issue(1'b0, 2'b01, 32'h0000_0300, 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_in);
            if (mc_to_if_done === 1'b1) break;
        end
        step(1);
        if_to_mc_ready = 1'b0;
        step(3);
        check("lb_result",     ld_res, 32'h0000_00A5);
        check("lb_latency",    32'(ld_cyc - valid_cyc), 32'd1);
        check("fetch_done",    32'(n_if - f0), 32'd1);
        check("fetch_inst",    if_inst, 32'h0403_0201);
        check("fetch_after_lb", 32'(if_cyc - ld_cyc), 32'd5);

        // SB to IO space with the buffer full for three cycles
        s0 = n_st; w0 = n_wr;
        io_buffer_full = 1'b1;
        lsb_issue(1'b1, 2'b01, 32'h0003_0000, 32'h0000_005A);
        step(2);
        io_buffer_full = 1'b0;
        step(5);
        check("io_nwrites",  32'(n_wr - w0), 32'd1);
        check("io_addr",     wr_a[w0], 32'h0003_0000);
        check("io_data",     {24'b0, wr_d[w0]}, 32'h0000_005A);
        check("io_wr_cyc",   32'(wr_c[w0] - valid_cyc), 32'd3);
        check("io_done_lat", 32'(st_cyc - valid_cyc), 32'd4);
        check("io_done_once", 32'(n_st - s0), 32'd1);

        // clr_in while fetch is on byte 2
        f0 = n_if;
        if_to_mc_addr  = 32'h0000_0400;
        if_to_mc_ready = 1'b1;
        step(3);
        clr_in = 1'b1;
        if_to_mc_ready = 1'b0;
        step(1);
        clr_in = 1'b0;
        @(negedge clk_in);
        check("clr_idle_bus", mem_a, 32'd0);
        step(8);
        check("clr_no_done", 32'(n_if - f0), 32'd0);

        // clr_in held through a LW has no effect
        l0 = n_ld;
        clr_in = 1'b1;
        lsb_issue(1'b0, 2'b11, 32'h0000_0100, 32'd0);
        step(8);
        clr_in = 1'b0;
        check("clr_lw_done",    32'(n_ld - l0), 32'd1);
        check("clr_lw_latency", 32'(ld_cyc - valid_cyc), 32'd4);
        check("clr_lw_result",  ld_res, 32'h4433_2211);

        // rdy_in low for two cycles in the middle of a LW
        l0 = n_ld; v0 = n_valid;
        lsb_issue(1'b0, 2'b11, 32'h0000_0100, 32'd0);
        rdy_in = 1'b0;
        step(2);
        rdy_in = 1'b1;
        step(12);
        check("frz_valid_once", 32'(n_valid - v0), 32'd1);
        check("frz_done_once",  32'(n_ld - l0), 32'd1);
        check("frz_result",     ld_res, 32'h4433_2211);

        // reset after the first byte of a SW
        s0 = n_st;
        lsb_to_mc_opType = `OPTYPE_ST; lsb_to_mc_len = 2'b11;
        lsb_to_mc_addr = 32'h0000_0500; lsb_to_mc_data = 32'h1122_3344;
        lsb_to_mc_ready = 1'b1;
        step(1);
        rst_in = 1'b1;
        lsb_to_mc_ready = 1'b0;
        @(negedge clk_in);
        check("rstm_first_wr", {31'b0, mem_wr}, 32'd1);
        step(1);
        @(negedge clk_in);
        check("rstm_mem_wr",   {31'b0, mem_wr}, 32'd0);
        check("rstm_mem_a",    mem_a, 32'd0);
        check("rstm_mem_dout", {24'b0, mem_dout}, 32'd0);
        check("rstm_result",   mc_to_lsb_result, 32'd0);
        step(1);
        rst_in = 1'b0;
        step(8);
        check("rstm_no_done", 32'(n_st - s0), 32'd0);
        check("rstm_ram", {16'b0, ram[16'h0501], ram[16'h0500]}, 32'h0000_0044);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
